// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: pixel width default, pooling window size and
// the 2x2 window type passed from the window generator to the max-pool stage.
package cnn_pkg;

  localparam int CNN_DATA_WIDTH = 8;
  localparam int WIN_SIZE       = 4;

  typedef logic [CNN_DATA_WIDTH-1:0] pixel_t;
  typedef pixel_t pool_win_t [0:WIN_SIZE-1];

endpackage

// File: rtl/cnn_line_buf.sv
// Single-row line buffer: one synchronous write port, two asynchronous read
// ports. Contents are not reset; the writer always fills a row before reading it.
import cnn_pkg::*;

module cnn_line_buf #(
  parameter int DATA_WIDTH = CNN_DATA_WIDTH,
  parameter int DEPTH      = 28,
  parameter int AW         = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr0,
  output logic [DATA_WIDTH-1:0] o_rdata0,
  input  logic [AW-1:0]         i_raddr1,
  output logic [DATA_WIDTH-1:0] o_rdata1
);

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata0 = r_mem[i_raddr0];
  assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/pool_window_gen.sv
// Turns a raster pixel stream into non-overlapping 2x2 pooling windows:
// even rows go to the line buffer, odd rows pair up with it to form windows.
import cnn_pkg::*;

module pool_window_gen #(
  parameter int DATA_WIDTH = CNN_DATA_WIDTH,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] pix_i,
  input  logic                  pix_valid_i,
  output logic                  pix_ready_o,
  output logic [DATA_WIDTH-1:0] win_o [0:WIN_SIZE-1],
  output logic                  win_valid_o,
  input  logic                  win_ready_i,
  output logic                  win_last_o
);

  localparam int CW = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  if ((IMG_WIDTH % 2) != 0 || IMG_WIDTH < 2) begin : g_bad_width
    $error("pool_window_gen: IMG_WIDTH must be even and >= 2");
  end
  if ((IMG_HEIGHT % 2) != 0 || IMG_HEIGHT < 2) begin : g_bad_height
    $error("pool_window_gen: IMG_HEIGHT must be even and >= 2");
  end

  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [DATA_WIDTH-1:0] r_bl;
  logic [DATA_WIDTH-1:0] r_win [0:WIN_SIZE-1];
  logic                  r_win_valid;
  logic                  r_win_last;

  logic                  w_xfer;
  logic                  w_row_odd;
  logic                  w_col_odd;
  logic                  w_completes;
  logic                  w_load;
  logic                  w_col_end;
  logic                  w_frame_end;
  logic [CW-1:0]         w_raddr_left;
  logic [DATA_WIDTH-1:0] w_rd_left;
  logic [DATA_WIDTH-1:0] w_rd_right;

  assign w_row_odd    = r_row[0];
  assign w_col_odd    = r_col[0];
  assign w_completes  = w_row_odd && w_col_odd;
  assign w_col_end    = (r_col == COL_LAST);
  assign w_frame_end  = w_col_end && (r_row == ROW_LAST);
  assign w_raddr_left = r_col & ~CW'(1);

  // Only a window-completing pixel needs the output register free.
  assign pix_ready_o = !(r_win_valid && !win_ready_i && w_completes);
  assign w_xfer      = pix_valid_i && pix_ready_o;
  assign w_load      = w_xfer && w_completes;

  cnn_line_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (IMG_WIDTH),
    .AW        (CW)
  ) u_line_buf (
    .i_clk   (clk_i),
    .i_we    (w_xfer && !w_row_odd),
    .i_waddr (r_col),
    .i_wdata (pix_i),
    .i_raddr0(w_raddr_left),
    .o_rdata0(w_rd_left),
    .i_raddr1(r_col),
    .o_rdata1(w_rd_right)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_col       <= '0;
      r_row       <= '0;
      r_bl        <= '0;
      r_win_valid <= 1'b0;
      r_win_last  <= 1'b0;
      for (int i = 0; i < WIN_SIZE; i++) begin
        r_win[i] <= '0;
      end
    end else begin
      if (w_xfer) begin
        if (w_col_end) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end

      if (w_xfer && w_row_odd && !w_col_odd) begin
        r_bl <= pix_i;
      end

      // A new window takes priority over clearing valid on consume.
      if (w_load) begin
        r_win[0]    <= w_rd_left;
        r_win[1]    <= w_rd_right;
        r_win[2]    <= r_bl;
        r_win[3]    <= pix_i;
        r_win_last  <= w_frame_end;
        r_win_valid <= 1'b1;
      end else if (win_ready_i) begin
        r_win_valid <= 1'b0;
      end
    end
  end

  assign win_o       = r_win;
  assign win_valid_o = r_win_valid;
  assign win_last_o  = r_win_last;

endmodule

// File: tb/tb_pool_window_gen.sv
// Scoreboard bench: a 4x4 instance for directed frames, stall and reset cases,
// and a 28x28 instance streaming three frames with random gaps and backpressure.
import cnn_pkg::*;

module tb_pool_window_gen;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] d;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4_n, pv4, pr4, wv4, wr4, wl4;
  logic [7:0] px4;
  logic [7:0] win4 [0:3];

  logic       rst28_n, pv28, pr28, wv28, wr28, wl28;
  logic [7:0] px28;
  logic [7:0] win28 [0:3];

  exp_t q4[$];
  exp_t q28[$];
  int   total = 0;
  int   bad   = 0;
  int   n_win4 = 0;
  int   n_win28 = 0;
  int   n_last28 = 0;
  logic done28 = 1'b0;

  pool_window_gen #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
    .clk_i(clk), .rst_ni(rst4_n), .pix_i(px4), .pix_valid_i(pv4), .pix_ready_o(pr4),
    .win_o(win4), .win_valid_o(wv4), .win_ready_i(wr4), .win_last_o(wl4)
  );

  pool_window_gen #(.DATA_WIDTH(8), .IMG_WIDTH(28), .IMG_HEIGHT(28)) dut28 (
    .clk_i(clk), .rst_ni(rst28_n), .pix_i(px28), .pix_valid_i(pv28), .pix_ready_o(pr28),
    .win_o(win28), .win_valid_o(wv28), .win_ready_i(wr28), .win_last_o(wl28)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic exp_t mk(input int base, input int o0, input int o1, input int o2,
                              input int o3, input logic last);
    exp_t e;
    e.a = 8'(base + o0);
    e.b = 8'(base + o1);
    e.c = 8'(base + o2);
    e.d = 8'(base + o3);
    e.last = last;
    return e;
  endfunction

  // Hand-computed 4x4 windows: pixel offsets of each window within the frame.
  function automatic exp_t win4x4(input int base, input int k);
    case (k)
      0:       return mk(base, 0, 1, 4, 5, 1'b0);
      1:       return mk(base, 2, 3, 6, 7, 1'b0);
      2:       return mk(base, 8, 9, 12, 13, 1'b0);
      default: return mk(base, 10, 11, 14, 15, 1'b1);
    endcase
  endfunction

  function automatic logic [7:0] pixval(input int f, input int r, input int c);
    return 8'(f * 53 + r * 28 + c * 3);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst4_n && wv4 && wr4) begin
      if (q4.size() == 0) begin
        total++; bad++;
        $display("FAIL dut4 unexpected window: got=%0h,%0h,%0h,%0h want=none",
                 win4[0], win4[1], win4[2], win4[3]);
      end else begin
        e = q4.pop_front();
        check("dut4 window", 64'({win4[0], win4[1], win4[2], win4[3], wl4}), 64'(e));
        n_win4++;
      end
    end
  end

  logic       prev_stall28 = 1'b0;
  logic [32:0] prev_win28 = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst28_n && prev_stall28) begin
      check("dut28 hold", 64'({wv28, win28[0], win28[1], win28[2], win28[3], wl28}),
            64'({1'b1, prev_win28}));
    end
    prev_stall28 = rst28_n && wv28 && !wr28;
    prev_win28   = {win28[0], win28[1], win28[2], win28[3], wl28};
    if (rst28_n && wv28 && wr28) begin
      if (q28.size() == 0) begin
        total++; bad++;
        $display("FAIL dut28 unexpected window: got=%0h,%0h,%0h,%0h want=none",
                 win28[0], win28[1], win28[2], win28[3]);
      end else begin
        e = q28.pop_front();
        check("dut28 window", 64'({win28[0], win28[1], win28[2], win28[3], wl28}), 64'(e));
        n_win28++;
        if (wl28) n_last28++;
      end
    end
  end

  task automatic send4(input logic [7:0] v);
    int n = 0;
    px4 = v;
    pv4 = 1'b1;
    while (1) begin
      @(negedge clk);
      if (pr4) break;
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL dut4 accept timeout: got=stalled want=accepted pixel %0d", v);
        break;
      end
    end
    @(posedge clk); #1;
    pv4 = 1'b0;
  endtask

  task automatic send28(input logic [7:0] v);
    int n = 0;
    px28 = v;
    pv28 = 1'b1;
    while (1) begin
      @(negedge clk);
      if (pr28) break;
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL dut28 accept timeout: got=stalled want=accepted");
        break;
      end
    end
    @(posedge clk); #1;
    pv28 = 1'b0;
  endtask

  task automatic reset4();
    pv4 = 1'b0;
    rst4_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset outputs", 64'({wv4, wl4, win4[0], win4[1], win4[2], win4[3]}), 64'(0));
    rst4_n = 1'b1;
    @(posedge clk); #1;
    check("ready after reset", 64'(pr4), 64'(1));
  endtask

  task automatic drain4(input string name);
    int n = 0;
    while (q4.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 64'(q4.size()), 64'(0));
  endtask

  initial begin
    px4 = '0; pv4 = 1'b0; wr4 = 1'b1; rst4_n = 1'b0;
    px28 = '0; pv28 = 1'b0; wr28 = 1'b1; rst28_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst28_n = 1'b1;

    // Two back-to-back 4x4 frames, downstream always ready; latency on frame 0.
    reset4();
    for (int i = 0; i < 32; i++) begin
      if ((i % 16) == 5)  q4.push_back(win4x4(i - 5, 0));
      if ((i % 16) == 7)  q4.push_back(win4x4(i - 7, 1));
      if ((i % 16) == 13) q4.push_back(win4x4(i - 13, 2));
      if ((i % 16) == 15) q4.push_back(win4x4(i - 15, 3));
      send4(8'(i));
      if (i < 16)
        check("valid one cycle after pixel", 64'(wv4),
              64'((i == 5 || i == 7 || i == 13 || i == 15) ? 1 : 0));
    end
    drain4("frames drained");
    check("dut4 window count", 64'(n_win4), 64'(8));

    // Backpressure: window 0 held, completing pixel 7 stalls, then consume+load.
    reset4();
    wr4 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) q4.push_back(win4x4(0, 0));
      send4(8'(i));
    end
    px4 = 8'd7;
    pv4 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall pix_ready", 64'(pr4), 64'(0));
      check("held window", 64'({wv4, win4[0], win4[1], win4[2], win4[3], wl4}),
            64'({1'b1, win4x4(0, 0)}));
    end
    @(posedge clk); #1;
    wr4 = 1'b1;
    q4.push_back(win4x4(0, 1));
    send4(8'd7);
    check("no bubble", 64'({wv4, win4[0], win4[1], win4[2], win4[3]}),
          64'({1'b1, 8'd2, 8'd3, 8'd6, 8'd7}));
    for (int i = 8; i < 16; i++) begin
      if (i == 13) q4.push_back(win4x4(0, 2));
      if (i == 15) q4.push_back(win4x4(0, 3));
      send4(8'(i));
    end
    drain4("stall frame drained");
    check("dut4 window count", 64'(n_win4), 64'(12));

    // Reset after pixel 9, then a clean frame 100..115.
    reset4();
    for (int i = 0; i < 10; i++) begin
      if (i == 5) q4.push_back(win4x4(0, 0));
      if (i == 7) q4.push_back(win4x4(0, 1));
      send4(8'(i));
    end
    drain4("partial drained");
    reset4();
    for (int i = 0; i < 16; i++) begin
      if (i == 5)  q4.push_back(win4x4(100, 0));
      if (i == 7)  q4.push_back(win4x4(100, 1));
      if (i == 13) q4.push_back(win4x4(100, 2));
      if (i == 15) q4.push_back(win4x4(100, 3));
      send4(8'(100 + i));
    end
    drain4("post-reset drained");
    check("dut4 window count", 64'(n_win4), 64'(18));

    // Three back-to-back 28x28 frames with random gaps and random backpressure.
    fork
      begin
        for (int f = 0; f < 3; f++) begin
          for (int r = 0; r < 28; r++) begin
            for (int c = 0; c < 28; c++) begin
              if ($urandom_range(0, 3) == 0) begin
                pv28 = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
              end
              if ((r % 2) == 1 && (c % 2) == 1) begin
                exp_t e;
                e.a = pixval(f, r - 1, c - 1);
                e.b = pixval(f, r - 1, c);
                e.c = pixval(f, r, c - 1);
                e.d = pixval(f, r, c);
                e.last = (r == 27 && c == 27);
                q28.push_back(e);
              end
              send28(pixval(f, r, c));
            end
          end
        end
        for (int n = 0; n < 2000 && q28.size() != 0; n++) begin
          @(posedge clk); #1;
        end
        done28 = 1'b1;
      end
      begin
        while (!done28) begin
          @(posedge clk); #1;
          wr28 = ($urandom_range(0, 3) != 0);
        end
        wr28 = 1'b1;
      end
    join

    check("dut28 queue empty", 64'(q28.size()), 64'(0));
    check("dut28 window count", 64'(n_win28), 64'(588));
    check("dut28 last count", 64'(n_last28), 64'(3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pool_window_gen.md
POOL_WINDOW_GEN -- requirements
Module: pool_window_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_WIDTH, default 28, pixels per input row (even, >=2).
REQ-003 SHALL have parameter IMG_HEIGHT, default 28, rows per input frame (even, >=2).
REQ-004 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have port pix_i  input  DATA_WIDTH  input pixel, raster order (row-major, left to right).
REQ-007 SHALL have port pix_valid_i  input  1  pix_i valid.
REQ-008 SHALL have port pix_ready_o  output  1  block accepts pix_i this cycle.
REQ-009 SHALL have port win_o  output  4 x DATA_WIDTH (unpacked [0:3])  2x2 pooling window.
REQ-010 SHALL have port win_valid_o  output  1  win_o valid.
REQ-011 SHALL have port win_ready_i  input  1  downstream max-pool stage consumes win_o.
REQ-012 SHALL have port win_last_o  output  1  win_o is last window of the frame (qualified by win_valid_o).

Function
REQ-013 Pixel transfer SHALL occur on a cycle with pix_valid_i && pix_ready_o; window transfer on win_valid_o && win_ready_i.
REQ-014 SHALL track column counter (0..IMG_WIDTH-1) and row counter (0..IMG_HEIGHT-1), advanced per pixel transfer; column wraps to 0 and increments row; row wraps to 0 after last pixel of frame.
REQ-015 Pixels of even rows SHALL be written to a line buffer of IMG_WIDTH entries at index = column.
REQ-016 On odd rows, pixel at even column c SHALL be held in a bottom-left register.
REQ-017 On accepting odd-row pixel at odd column c, SHALL load win_o with [0]=buf[c-1], [1]=buf[c], [2]=bottom-left reg, [3]=pix_i, and set win_valid_o next cycle (latency 1 cycle).
REQ-018 Windows SHALL be non-overlapping, stride 2; exactly (IMG_WIDTH/2)*(IMG_HEIGHT/2) windows per frame.
REQ-019 win_last_o SHALL be 1 only with the window formed from the final pixel of the frame (row IMG_HEIGHT-1, column IMG_WIDTH-1).
REQ-020 win_o, win_last_o SHALL stay stable while win_valid_o && !win_ready_i.
REQ-021 win_valid_o SHALL clear after transfer unless a new window is loaded in the same cycle (simultaneous consume+load: new window wins, valid stays 1).
REQ-022 pix_ready_o SHALL be 1 except when win_valid_o && !win_ready_i && the next accepted pixel would complete a window (odd row, odd column); no combinational path from pix_valid_i to pix_ready_o.
REQ-023 Line buffer of an even row SHALL not be overwritten before its last window is formed (guaranteed by raster order; no extra stall).
REQ-024 Consecutive frames SHALL stream back-to-back without idle cycles.

Reset
REQ-025 On rst_ni low: counters=0, win_valid_o=0, win_last_o=0, win_o=0, bottom-left reg=0, pix_ready_o=1 after release; line buffer contents need not reset.
REQ-026 Reset asserted mid-frame SHALL discard partial frame; first pixel after release is row 0, column 0.

Structure
REQ-027 DATA_WIDTH default and window size constant (4) SHALL live in shared package cnn_pkg, together with typedef pool_win_t (unpacked array of 4 pixels) used by this block and max_pool input.
REQ-028 Line buffer SHALL be sub-module cnn_line_buf (single write port, two read ports, depth IMG_WIDTH, no reset).
REQ-029 Elaboration SHALL fail if IMG_WIDTH or IMG_HEIGHT is odd or <2.

Verification
REQ-030 4x4 frame, pixels 0..15, win_ready_i=1 -> windows {0,1,4,5},{2,3,6,7},{8,9,12,13},{10,11,14,15}; win_last_o only on 4th; each 1 cycle after pixels 5,7,13,15.
REQ-031 4x4, win_ready_i=0 from first window -> win_o held {0,1,4,5}, pix_ready_o drops when pixel 7 is next; raise win_ready_i -> stream resumes, no loss/duplication.
REQ-032 Random pix_valid_i gaps and random win_ready_i over 3 back-to-back 28x28 frames -> 196 windows/frame, contents match reference model, win_last_o count = 3.
REQ-033 Reset asserted after pixel 9 of a 4x4 frame, then full frame 100..115 -> first window {100,101,104,105}, no window from partial data.
REQ-034 Window completing on cycle where previous window is consumed -> win_valid_o stays 1, new contents appear, no bubble.
